// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction formats, field positions, opcodes and
// loader FSM states, plus the field-to-word packing used by the loader.
package mips_pkg;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_ILL = 2'd3;

  localparam int OPC_MSB = 31;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int SH_LSB  = 6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic        last;
    logic [31:0] word;
  } fifo_entry_t;

  // An illegal format yields only the opcode; the loader never stores it.
  function automatic logic [31:0] encode_word(
    input logic [1:0]  fmt,
    input logic [5:0]  opcode,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = '0;
    w[OPC_MSB -: 6] = opcode;
    case (fmt)
      FMT_R: begin
        w[RS_LSB +: 5] = rs;
        w[RT_LSB +: 5] = rt;
        w[RD_LSB +: 5] = rd;
        w[SH_LSB +: 5] = shamt;
        w[5:0]         = funct;
      end
      FMT_I: begin
        w[RS_LSB +: 5] = rs;
        w[RT_LSB +: 5] = rt;
        w[15:0]        = imm;
      end
      FMT_J: w[25:0] = target;
      default: w = w;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered single-clock FIFO with flush; a word pushed in cycle N is
// visible at the head from cycle N+1.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   LVL_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   LVL_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_level == LVL_FULL);
  assign empty_o = (r_level == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign rdata_o = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/encode_loader.sv
// Packs MIPS instruction fields into 32-bit words, buffers them and writes
// them to instruction memory at consecutive addresses from a session base.
module encode_loader
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [AW-1:0] base_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic          last_i,
  input  logic [1:0]    fmt_i,
  input  logic [5:0]    opcode_i,
  input  logic [4:0]    rs_i,
  input  logic [4:0]    rt_i,
  input  logic [4:0]    rd_i,
  input  logic [4:0]    shamt_i,
  input  logic [5:0]    funct_i,
  input  logic [15:0]   imm_i,
  input  logic [25:0]   target_i,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_data_o,
  input  logic          mem_ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [15:0]   count_o
);

  logic [1:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_count;
  logic          r_err;

  logic          w_accept;
  logic          w_illegal;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_full;
  logic          w_empty;
  fifo_entry_t   w_wentry;
  fifo_entry_t   w_head;

  assign w_accept  = valid_i && ready_o;
  assign w_illegal = (fmt_i == FMT_ILL);
  assign w_push    = w_accept && !w_illegal;
  assign w_flush   = (r_state == ST_IDLE) && start_i;
  assign w_pop     = mem_we_o && mem_ready_i;

  assign w_wentry.last = last_i;
  assign w_wentry.word = encode_word(fmt_i, opcode_i, rs_i, rt_i, rd_i,
                                     shamt_i, funct_i, imm_i, target_i);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (w_flush),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_wentry),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign ready_o    = (r_state == ST_LOAD) && !w_full;
  assign busy_o     = (r_state != ST_IDLE);
  assign done_o     = (r_state == ST_DONE);
  assign mem_we_o   = busy_o && !w_empty;
  assign mem_addr_o = r_addr;
  assign mem_data_o = mem_we_o ? w_head.word : 32'd0;
  assign err_o      = r_err;
  assign count_o    = r_count;

  // An illegal final word leaves DRAIN with nothing queued, so an empty FIFO
  // also ends the session.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start_i) r_state <= ST_LOAD;
        ST_LOAD:  if (w_accept && last_i) r_state <= ST_DRAIN;
        ST_DRAIN: if ((w_pop && w_head.last) || w_empty) r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_flush) begin
      r_addr  <= base_i & ~AW'(3);
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr <= r_addr + AW'(4);
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
      if (w_accept && w_illegal) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_encode_loader.sv
// Directed bench for encode_loader: drives field descriptions, logs memory
// writes and compares them with hand-encoded words and addresses.
module tb_encode_loader;
  import mips_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i = 1'b0;
  logic [31:0] base_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        last_i = 1'b0;
  logic [1:0]  fmt_i = '0;
  logic [5:0]  opcode_i = '0;
  logic [4:0]  rs_i = '0, rt_i = '0, rd_i = '0, shamt_i = '0;
  logic [5:0]  funct_i = '0;
  logic [15:0] imm_i = '0;
  logic [25:0] target_i = '0;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] count_o;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [31:0] logAddr[$];
  logic [31:0] logData[$];
  int          logCyc[$];

  encode_loader #(.DEPTH(4), .AW(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_i(base_i),
    .valid_i(valid_i), .ready_o(ready_o), .last_i(last_i), .fmt_i(fmt_i),
    .opcode_i(opcode_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .shamt_i(shamt_i), .funct_i(funct_i), .imm_i(imm_i), .target_i(target_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ready_i(mem_ready_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Writes commit on the next rising edge; sample mid-way through low phase.
  always @(negedge clk_i) begin
    cyc++;
    #2;
    if (rst_ni === 1'b1 && mem_we_o === 1'b1 && mem_ready_i === 1'b1) begin
      logAddr.push_back(mem_addr_o);
      logData.push_back(mem_data_o);
      logCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
    logCyc.delete();
  endtask

  task automatic startSession(input logic [31:0] base);
    @(negedge clk_i);
    start_i = 1'b1;
    base_i  = base;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] fmt,
                               input logic [5:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [4:0] sh, input logic [5:0] fn,
                               input logic [15:0] imm, input logic [25:0] tgt,
                               input logic last);
    int waited;
    fmt_i = fmt; opcode_i = op; rs_i = rs; rt_i = rt; rd_i = rd;
    shamt_i = sh; funct_i = fn; imm_i = imm; target_i = tgt; last_i = last;
    valid_i = 1'b1;
    #1;
    waited = 0;
    while (ready_o !== 1'b1 && waited < 40) begin
      @(negedge clk_i);
      #1;
      waited++;
    end
    if (waited >= 40) checkOutput({tag, "_accept_timeout"}, {31'd0, ready_o}, 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    last_i  = 1'b0;
    #1;
  endtask

  task automatic sendI(input string tag, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [15:0] imm, input logic last);
    applyStimulus(tag, FMT_I, op, rs, rt, 5'd0, 5'd0, 6'd0, imm, 26'd0, last);
  endtask

  task automatic waitDone(input string tag);
    int waited;
    waited = 0;
    while (done_o !== 1'b1 && waited < 60) begin
      @(negedge clk_i);
      #1;
      waited++;
    end
    checkOutput({tag, "_done"}, {31'd0, done_o}, 32'd1);
    @(negedge clk_i);
    #1;
    checkOutput({tag, "_done_single"}, {31'd0, done_o}, 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic checkWrite(input string tag, input int idx,
                            input logic [31:0] addr, input logic [31:0] data);
    checkOutput($sformatf("%s_addr%0d", tag, idx),
                (idx < logAddr.size()) ? logAddr[idx] : 32'hxxxx_xxxx, addr);
    checkOutput($sformatf("%s_data%0d", tag, idx),
                (idx < logData.size()) ? logData[idx] : 32'hxxxx_xxxx, data);
  endtask

  initial begin
    logic [31:0] bpWords [6];
    bpWords = '{32'h2001_0001, 32'h2002_0002, 32'h2003_0003,
                32'h2004_0004, 32'h2005_0005, 32'h2006_0006};

    // Reset values
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_ready", {31'd0, ready_o}, 32'd0);
    checkOutput("rst_we", {31'd0, mem_we_o}, 32'd0);
    checkOutput("rst_addr", mem_addr_o, 32'd0);
    checkOutput("rst_data", mem_data_o, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    checkOutput("rst_err", {31'd0, err_o}, 32'd0);
    checkOutput("rst_count", {16'd0, count_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // R-type single word: add $3,$1,$2
    clearLog();
    startSession(32'h0000_0100);
    checkOutput("r_busy", {31'd0, busy_o}, 32'd1);
    checkOutput("r_ready", {31'd0, ready_o}, 32'd1);
    checkOutput("r_base", mem_addr_o, 32'h0000_0100);
    checkOutput("r_we_before", {31'd0, mem_we_o}, 32'd0);
    applyStimulus("r", FMT_R, OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, FN_ADD, 16'd0, 26'd0, 1'b1);
    checkOutput("r_latency_we", {31'd0, mem_we_o}, 32'd1);
    checkOutput("r_ready_drain", {31'd0, ready_o}, 32'd0);
    waitDone("r");
    checkOutput("r_nwrites", logAddr.size(), 32'd1);
    checkWrite("r", 0, 32'h0000_0100, 32'h0022_1820);
    checkOutput("r_count", {16'd0, count_o}, 32'd1);

    // I-type back-to-back, no bubbles after the first write
    clearLog();
    startSession(32'h0000_0200);
    sendI("i0", OP_ADDI, 5'd0, 5'd8, 16'h0005, 1'b0);
    sendI("i1", OP_LW, 5'd29, 5'd2, 16'hFFFC, 1'b0);
    sendI("i2", OP_SW, 5'd29, 5'd3, 16'h0008, 1'b0);
    sendI("i3", OP_BEQ, 5'd1, 5'd2, 16'hFFFF, 1'b1);
    waitDone("i");
    checkOutput("i_nwrites", logAddr.size(), 32'd4);
    checkWrite("i", 0, 32'h0000_0200, 32'h2008_0005);
    checkWrite("i", 1, 32'h0000_0204, 32'h8FA2_FFFC);
    checkWrite("i", 2, 32'h0000_0208, 32'hAFA3_0008);
    checkWrite("i", 3, 32'h0000_020C, 32'h1022_FFFF);
    for (int k = 1; k < 4; k++)
      checkOutput($sformatf("i_nobubble%0d", k),
                  (k < logCyc.size()) ? logCyc[k] - logCyc[k-1] : -1, 32'd1);
    checkOutput("i_count", {16'd0, count_o}, 32'd4);

    // J-type with address wrap; low base bits are ignored
    clearLog();
    startSession(32'hFFFF_FFFF);
    checkOutput("j_base_mask", mem_addr_o, 32'hFFFF_FFFC);
    applyStimulus("j0", FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h40, 1'b0);
    applyStimulus("j1", FMT_J, OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h100, 1'b1);
    waitDone("j");
    checkWrite("j", 0, 32'hFFFF_FFFC, 32'h0800_0040);
    checkWrite("j", 1, 32'h0000_0000, 32'h0C00_0100);

    // Backpressure: FIFO fills after four accepts, head stays stable
    clearLog();
    mem_ready_i = 1'b0;
    startSession(32'h0000_0300);
    for (int k = 0; k < 4; k++)
      sendI($sformatf("bp%0d", k), OP_ADDI, 5'd0, 5'(k+1), 16'(k+1), 1'b0);
    checkOutput("bp_full_ready", {31'd0, ready_o}, 32'd0);
    checkOutput("bp_we", {31'd0, mem_we_o}, 32'd1);
    checkOutput("bp_count0", {16'd0, count_o}, 32'd0);
    startSession(32'h0000_7000);
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("bp_start_ignored", {31'd0, busy_o}, 32'd1);
    checkOutput("bp_addr_stable", mem_addr_o, 32'h0000_0300);
    checkOutput("bp_data_stable", mem_data_o, bpWords[0]);
    checkOutput("bp_still_full", {31'd0, ready_o}, 32'd0);
    mem_ready_i = 1'b1;
    sendI("bp4", OP_ADDI, 5'd0, 5'd5, 16'd5, 1'b0);
    sendI("bp5", OP_ADDI, 5'd0, 5'd6, 16'd6, 1'b1);
    waitDone("bp");
    checkOutput("bp_nwrites", logAddr.size(), 32'd6);
    for (int k = 0; k < 6; k++)
      checkWrite("bp", k, 32'h0000_0300 + 32'(4*k), bpWords[k]);
    checkOutput("bp_count", {16'd0, count_o}, 32'd6);

    // Illegal format mid-stream: skipped, no address gap, sticky error
    clearLog();
    startSession(32'h0000_0400);
    sendI("ill0", OP_ADDI, 5'd0, 5'd1, 16'd1, 1'b0);
    applyStimulus("ill1", FMT_ILL, 6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 6'h3F, 16'hFFFF, 26'h3FF_FFFF, 1'b0);
    checkOutput("ill_err_set", {31'd0, err_o}, 32'd1);
    applyStimulus("ill2", FMT_R, OP_RTYPE, 5'd1, 5'd2, 5'd4, 5'd0, FN_ADD, 16'd0, 26'd0, 1'b1);
    waitDone("ill");
    checkOutput("ill_err_sticky", {31'd0, err_o}, 32'd1);
    checkOutput("ill_nwrites", logAddr.size(), 32'd2);
    checkWrite("ill", 0, 32'h0000_0400, 32'h2001_0001);
    checkWrite("ill", 1, 32'h0000_0404, 32'h0022_2020);
    checkOutput("ill_count", {16'd0, count_o}, 32'd2);

    // Illegal last word still ends the session
    clearLog();
    startSession(32'h0000_0500);
    checkOutput("ill_err_cleared", {31'd0, err_o}, 32'd0);
    sendI("il0", OP_ADDI, 5'd0, 5'd5, 16'd5, 1'b0);
    applyStimulus("il1", FMT_ILL, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
    waitDone("illast");
    checkOutput("illast_nwrites", logAddr.size(), 32'd1);
    checkWrite("illast", 0, 32'h0000_0500, 32'h2005_0005);
    checkOutput("illast_err", {31'd0, err_o}, 32'd1);

    // Reset with buffered words discards them
    clearLog();
    mem_ready_i = 1'b0;
    startSession(32'h0000_0600);
    for (int k = 0; k < 3; k++)
      sendI($sformatf("rs%0d", k), OP_ADDI, 5'd0, 5'(k+1), 16'(k+1), 1'b0);
    checkOutput("rs_we_pre", {31'd0, mem_we_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    checkOutput("rs_we", {31'd0, mem_we_o}, 32'd0);
    checkOutput("rs_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rs_ready", {31'd0, ready_o}, 32'd0);
    checkOutput("rs_addr", mem_addr_o, 32'd0);
    checkOutput("rs_err", {31'd0, err_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_ready_i = 1'b1;
    repeat (10) @(negedge clk_i);
    #1;
    checkOutput("rs_no_writes", logAddr.size(), 32'd0);
    checkOutput("rs_we_after", {31'd0, mem_we_o}, 32'd0);

    // Fresh session after reset works normally
    startSession(32'h0000_0700);
    applyStimulus("post", FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h40, 1'b1);
    waitDone("post");
    checkOutput("post_nwrites", logAddr.size(), 32'd1);
    checkWrite("post", 0, 32'h0000_0700, 32'h0800_0040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
